instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Sequential fetch front end that produces the `Instruction` word consumed by the single-cycle datapath.
- Consumes the datapath's `Zero`, `Sign` and `Imm` outputs to choose the next PC.
- Holds one instruction stable until the datapath asserts `Advance`, then computes the next PC and issues one request on a valid/ready instruction-memory interface with variable latency.
- Flags misaligned control-flow targets and counts retired instructions.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset; must be 4-byte aligned.
NOP_WORD, 32'h00000013, value driven on `Instruction` while no instruction is valid.

Ports:
CLK  in  1  clock, rising edge
RST_n  in  1  reset, synchronous, active-low
IMemReqValid  out  1  fetch request valid
IMemReqReady  in  1  memory accepts request
IMemAddr  out  32  fetch address (equals PC)
IMemRespValid  in  1  response data valid
IMemRespData  in  32  fetched instruction word
Instruction  out  32  instruction presented to datapath
InstrValid  out  1  `Instruction` is valid for execution
InstrPC  out  32  PC of `Instruction`
PCPlus4  out  32  InstrPC+4 (link value for JAL/JALR)
Advance  in  1  datapath has executed current instruction
Branch  in  1  current instruction is conditional branch
Jump  in  1  current instruction is JAL
JumpReg  in  1  current instruction is JALR
BranchType  in  3  funct3 of current branch
Zero  in  1  ALU zero flag
Sign  in  1  ALU less-than result for the selected compare
Imm  in  32  sign-extended immediate
RegBase  in  32  rs1 value for JALR
Fault  out  1  misaligned-target fault, sticky
RetireCount  out  32  instructions retired, wraps

Behaviour:
- Clock and reset: single clock `CLK`; reset `RST_n` is synchronous and active-low, sampled only on the rising edge.
- Reset values (while `RST_n`=0, and at the first edge after release):
  - state=REQ, PC=RESET_PC.
  - IMemReqValid=0 while `RST_n`=0; it becomes 1 combinationally in REQ once `RST_n`=1.
  - InstrValid=0, Instruction=NOP_WORD, InstrPC=RESET_PC, PCPlus4=RESET_PC+4, Fault=0, RetireCount=0.
- States: REQ, WAIT, HOLD, FAULT.
  - REQ: IMemReqValid=1, IMemAddr=PC, stable until accepted. On the edge with IMemReqReady=1 -> WAIT.
  - WAIT: IMemReqValid=0. On the edge with IMemRespValid=1: capture IMemRespData into Instruction, set InstrValid=1 -> HOLD. The memory never responds in the same cycle as acceptance (minimum latency 1).
  - HOLD: Instruction, InstrPC and InstrValid stay stable. On the edge with Advance=1: load the next PC, increment RetireCount, set InstrValid=0 and Instruction=NOP_WORD -> REQ, or -> FAULT if the next PC is misaligned.
  - FAULT: Fault=1, IMemReqValid=0, InstrValid=0. Only reset exits.
- Next PC (priority order, all arithmetic mod 2^32):
  - JumpReg: (RegBase+Imm) & ~32'h1.
  - Jump: InstrPC+Imm.
  - Branch and taken: InstrPC+Imm.
  - Otherwise: InstrPC+4.
- Branch taken rule by BranchType:
  - 000: Zero.
  - 001: !Zero.
  - 100, 110: Sign.
  - 101, 111: !Sign.
  - 010, 011: never taken.
- Misaligned target: next PC[1:0]!=0 -> FAULT. InstrPC stays the faulting instruction's PC, and RetireCount still increments for that instruction.
- Ignored inputs (no effect, no state change):
  - Advance outside HOLD.
  - IMemRespValid outside WAIT.
  - Control inputs (Branch, Jump, JumpReg, BranchType, Zero, Sign, Imm, RegBase) when Advance=0.
- Outstanding requests: at most one; no speculative fetch.
- Throughput with a zero-wait memory and Advance tied high: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Reset mid-operation: an asserted RST_n=0 in any state returns to the reset values at that edge. A response arriving in the first post-reset REQ cycle is ignored.
- RetireCount: wraps from 32'hFFFFFFFF to 0.

Test Plan:
- Reset release, memory ready=1, latency 1, Advance=1, no control: IMemAddr sequence 0,4,8,C, one request every 3 cycles; RetireCount=3 after the third HOLD exit.
- BEQ: BranchType=000, Zero=1, Imm=-8, InstrPC=0x20 -> next IMemAddr=0x18. Repeat with Zero=0 -> next IMemAddr=0x24.
- JALR: RegBase=0x101, Imm=0x4 -> IMemAddr=0x104, PCPlus4=InstrPC+4. JumpReg and Branch asserted together -> JALR target wins.
- Backpressure: IMemReqReady=0 for 5 cycles -> IMemReqValid=1 and IMemAddr stable throughout. Memory latency 4 -> InstrValid=0 until the response, Instruction stays NOP_WORD.
- Misaligned JAL: Imm=0x6, InstrPC=0x40 -> Fault=1, no further requests, InstrPC=0x40. Advance pulses afterwards have no effect until RST_n=0.
- RST_n=0 for one cycle while in WAIT, then a stale IMemRespValid pulse -> pulse ignored, IMemAddr=RESET_PC, InstrValid=0, RetireCount=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: one outstanding request on a valid/ready instruction memory,
// holds the fetched word until the datapath advances, then resolves the next PC.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST_n,
   output logic        IMemReqValid,
   input  logic        IMemReqReady,
   output logic [31:0] IMemAddr,
   input  logic        IMemRespValid,
   input  logic [31:0] IMemRespData,
   output logic [31:0] Instruction,
   output logic        InstrValid,
   output logic [31:0] InstrPC,
   output logic [31:0] PCPlus4,
   input  logic        Advance,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        JumpReg,
   input  logic [2:0]  BranchType,
   input  logic        Zero,
   input  logic        Sign,
   input  logic [31:0] Imm,
   input  logic [31:0] RegBase,
   output logic        Fault,
   output logic [31:0] RetireCount
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_t;

   state_t      state;
   logic [31:0] pc;
   logic        taken_c;
   logic [31:0] next_pc_c;

   // Branch condition from funct3; 010/011 are not branch encodings.
   always_comb begin
      taken_c = 1'b0;
      case (BranchType)
         3'b000:         taken_c = Zero;
         3'b001:         taken_c = !Zero;
         3'b100, 3'b110: taken_c = Sign;
         3'b101, 3'b111: taken_c = !Sign;
         default:        taken_c = 1'b0;
      endcase
   end

   // Next PC selection, JALR highest priority.
   always_comb begin
      next_pc_c = InstrPC + 32'd4;
      if (JumpReg)
         next_pc_c = (RegBase + Imm) & ~32'h1;
      else if (Jump || (Branch && taken_c))
         next_pc_c = InstrPC + Imm;
   end

   // The request line is the only combinational output so it drops during reset.
   assign IMemReqValid = RST_n && (state == S_REQ);
   assign IMemAddr     = pc;

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state       <= S_REQ;
         pc          <= RESET_PC;
         InstrValid  <= 1'b0;
         Instruction <= NOP_WORD;
         InstrPC     <= RESET_PC;
         PCPlus4     <= RESET_PC + 32'd4;
         Fault       <= 1'b0;
         RetireCount <= 32'd0;
      end else begin
         case (state)
            S_REQ: begin
               if (IMemReqReady)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (IMemRespValid) begin
                  Instruction <= IMemRespData;
                  InstrValid  <= 1'b1;
                  InstrPC     <= pc;
                  PCPlus4     <= pc + 32'd4;
                  state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (Advance) begin
                  pc          <= next_pc_c;
                  RetireCount <= RetireCount + 32'd1;
                  InstrValid  <= 1'b0;
                  Instruction <= NOP_WORD;
                  if (next_pc_c[1:0] != 2'b00) begin
                     Fault <= 1'b1;
                     state <= S_FAULT;
                  end else begin
                     state <= S_REQ;
                  end
               end
            end
            S_FAULT: begin
               // Terminal until reset; Fault is held.
               Fault <= 1'b1;
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule
